// File: rtl/m_best_move_selector.sv
// Best-move selector: scans the seven columns of a 6x7 board one per cycle, scores
// each legal drop with m_evaluation_func and reports the highest-scoring column.
`ifndef FIELD_SIZE
`define FIELD_SIZE 42
`endif
`ifndef COL_COUNT
`define COL_COUNT 7
`endif
`ifndef ROW_COUNT
`define ROW_COUNT 6
`endif

// Static evaluator: a four-in-a-row for the side to move saturates the score,
// otherwise it is a centre-weighted material balance (column weights 1,2,3,4,3,2,1).
module m_evaluation_func (
    input  logic [`FIELD_SIZE-1:0] i_me_field,
    input  logic [`FIELD_SIZE-1:0] i_op_field,
    output logic signed [15:0]     o_score
);
    function automatic logic signed [15:0] col_weight(input int c);
        int d;
        d = (c > 3) ? (c - 3) : (3 - c);
        return 16'(4 - d);
    endfunction

    function automatic logic has_four(input logic [`FIELD_SIZE-1:0] f);
        logic w;
        w = 1'b0;
        for (int r = 0; r < `ROW_COUNT; r++)
            for (int c = 0; c <= `COL_COUNT - 4; c++)
                w = w | (f[r*`COL_COUNT+c] & f[r*`COL_COUNT+c+1] &
                         f[r*`COL_COUNT+c+2] & f[r*`COL_COUNT+c+3]);
        for (int r = 0; r <= `ROW_COUNT - 4; r++)
            for (int c = 0; c < `COL_COUNT; c++)
                w = w | (f[r*`COL_COUNT+c] & f[(r+1)*`COL_COUNT+c] &
                         f[(r+2)*`COL_COUNT+c] & f[(r+3)*`COL_COUNT+c]);
        for (int r = 0; r <= `ROW_COUNT - 4; r++)
            for (int c = 0; c <= `COL_COUNT - 4; c++)
                w = w | (f[r*`COL_COUNT+c] & f[(r+1)*`COL_COUNT+c+1] &
                         f[(r+2)*`COL_COUNT+c+2] & f[(r+3)*`COL_COUNT+c+3]);
        for (int r = 0; r <= `ROW_COUNT - 4; r++)
            for (int c = 3; c < `COL_COUNT; c++)
                w = w | (f[r*`COL_COUNT+c] & f[(r+1)*`COL_COUNT+c-1] &
                         f[(r+2)*`COL_COUNT+c-2] & f[(r+3)*`COL_COUNT+c-3]);
        return w;
    endfunction

    logic signed [15:0] pos_sum;

    always_comb begin
        pos_sum = '0;
        for (int i = 0; i < `FIELD_SIZE; i++) begin
            if (i_me_field[i]) pos_sum = pos_sum + col_weight(i % `COL_COUNT);
            if (i_op_field[i]) pos_sum = pos_sum - col_weight(i % `COL_COUNT);
        end
        o_score = has_four(i_me_field) ? 16'sh7FFF : pos_sum;
    end
endmodule

module m_best_move_selector (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [`FIELD_SIZE-1:0] i_me_field,
    input  logic [`FIELD_SIZE-1:0] i_op_field,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_valid,
    output logic [2:0]             o_best_col,
    output logic signed [15:0]     o_best_score
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [`FIELD_SIZE-1:0]  me_q, me_d, op_q, op_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [2:0]              best_col_q, best_col_d;
    logic signed [15:0]      best_score_q, best_score_d;
    logic                    found_q, found_d;
    logic                    ev_vld_q, ev_vld_d, ev_legal_q, ev_legal_d;
    logic [2:0]              ev_col_q, ev_col_d;
    logic signed [15:0]      ev_score_q, ev_score_d;
    logic                    out_valid_q, out_valid_d;
    logic [2:0]              out_col_q, out_col_d;
    logic signed [15:0]      out_score_q, out_score_d;

    logic [`FIELD_SIZE-1:0]  occ, cand_field;
    logic [2:0]              scan_col;
    logic                    col_legal, take;
    int                      col_i, drop_row;
    logic signed [15:0]      eval_score;

    m_evaluation_func u_eval (
        .i_me_field (cand_field),
        .i_op_field (op_q),
        .o_score    (eval_score)
    );

    always_comb begin
        occ      = me_q | op_q;
        scan_col = (cnt_q == 3'd7) ? 3'd0 : cnt_q;
        col_i    = int'(scan_col);
        col_legal = (cnt_q != 3'd7) && !occ[col_i];
        drop_row = 0;
        for (int r = 0; r < `ROW_COUNT; r++)
            if (!occ[r*`COL_COUNT+col_i]) drop_row = r;
        cand_field = col_legal ? (me_q | (`FIELD_SIZE'(1) << (drop_row*`COL_COUNT + col_i)))
                               : me_q;
        take = ev_vld_q && ev_legal_q && (!found_q || (ev_score_q > best_score_q));
    end

    // The evaluator output is registered (ev_*) and compared one cycle later, so the
    // scan spends one extra cycle at counter 7 draining the last column's score.
    always_comb begin
        state_d      = state_q;
        me_d         = me_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        best_col_d   = best_col_q;
        best_score_d = best_score_q;
        found_d      = found_q;
        ev_vld_d     = 1'b0;
        ev_legal_d   = ev_legal_q;
        ev_col_d     = ev_col_q;
        ev_score_d   = ev_score_q;
        out_valid_d  = out_valid_q;
        out_col_d    = out_col_q;
        out_score_d  = out_score_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d      = SCAN;
                    me_d         = i_me_field;
                    op_d         = i_op_field;
                    cnt_d        = 3'd0;
                    best_col_d   = 3'd7;
                    best_score_d = 16'sh8000;
                    found_d      = 1'b0;
                end
            end
            SCAN: begin
                if (take) begin
                    best_col_d   = ev_col_q;
                    best_score_d = ev_score_q;
                    found_d      = 1'b1;
                end
                ev_col_d   = cnt_q;
                ev_legal_d = col_legal;
                ev_score_d = eval_score;
                if (cnt_q == 3'd7) begin
                    state_d     = DONE;
                    out_valid_d = found_d;
                    out_col_d   = best_col_d;
                    out_score_d = best_score_d;
                end else begin
                    ev_vld_d = 1'b1;
                    cnt_d    = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            me_q         <= '0;
            op_q         <= '0;
            cnt_q        <= 3'd0;
            best_col_q   <= 3'd7;
            best_score_q <= 16'sh8000;
            found_q      <= 1'b0;
            ev_vld_q     <= 1'b0;
            ev_legal_q   <= 1'b0;
            ev_col_q     <= 3'd0;
            ev_score_q   <= '0;
            out_valid_q  <= 1'b0;
            out_col_q    <= 3'd7;
            out_score_q  <= 16'sh8000;
        end else begin
            state_q      <= state_d;
            me_q         <= me_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            best_col_q   <= best_col_d;
            best_score_q <= best_score_d;
            found_q      <= found_d;
            ev_vld_q     <= ev_vld_d;
            ev_legal_q   <= ev_legal_d;
            ev_col_q     <= ev_col_d;
            ev_score_q   <= ev_score_d;
            out_valid_q  <= out_valid_d;
            out_col_q    <= out_col_d;
            out_score_q  <= out_score_d;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_valid      = out_valid_q;
    assign o_best_col   = out_col_q;
    assign o_best_score = out_score_q;
endmodule
